fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
- Sequences the Fibonacci datapath: owns the dual-port scratch RAM (port A write, port B read) and the N>=2 adder, and computes fib(N) with fib(0)=fib(1)=1.
- Sits beside the MU0 control state machine. On the FBC instruction it takes N from IR[11:0] and holds the CPU in EXEC until done.
- Keeps the RAM as a memo table, so repeat or smaller N is a single RAM read and larger N resumes from the highest computed index.

Parameters:
- DATA_W, 16: result and RAM data width.
- ADDR_W, 12: width of N and of the RAM addresses.
- DEPTH, 256: number of RAM words; valid N is 0..DEPTH-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a computation; sampled only in IDLE.
- n_in  in  ADDR_W  index N; sampled with start.
- flush  in  1  invalidate the memo table.
- busy  out  1  high in every state except IDLE; drives the CPU EXEC hold.
- done  out  1  one-cycle pulse when result is valid.
- result  out  DATA_W  fib(N); held until the next done.
- err  out  1  N >= DEPTH; updated at done.
- ram_wren  out  1  port A write enable.
- ram_addr_a  out  ADDR_W  port A address.
- ram_data_a  out  DATA_W  port A write data.
- ram_addr_b  out  ADDR_W  port B read address.
- ram_q_b  in  DATA_W  port B read data; synchronous RAM, valid one cycle after the address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, err=0, ram_wren=0, both addresses 0.
  - memo_valid=0, hi_idx=0, prev=cur=0, flush_pend=0.
  - A reset mid-operation aborts the computation. RAM contents are then treated as invalid.
- States: IDLE, INIT0, INIT1, CALC, LOOKUP, RDWAIT, DONE.
- Cycle 0 is the IDLE cycle in which start=1. The decision is made on that cycle's edge:
  - N >= DEPTH -> DONE with err=1, result=0; done in cycle 1.
  - N <= 1 -> DONE with result=1; done in cycle 1; no RAM access.
  - memo_valid and N <= hi_idx -> LOOKUP.
    - Cycle 1 drives ram_addr_b=N.
    - Cycle 2 (RDWAIT) captures ram_q_b into result at the end of the cycle.
    - Cycle 3 is DONE. No writes occur.
  - memo_valid=0 -> cold path.
    - INIT0 writes RAM[0]=1.
    - INIT1 writes RAM[1]=1 and sets prev=cur=1, i=1.
    - CALC, once per cycle:
      - next=prev+cur; write RAM[i+1]=next.
      - prev<=cur, cur<=next, i<=i+1, hi_idx<=i+1.
      - When i+1==N, result<=next and go to DONE.
    - done is in cycle N+2.
  - memo_valid and N > hi_idx -> warm path: CALC directly from i=hi_idx using the retained prev/cur; done in cycle N-hi_idx+1.
- memo_valid is set at the end of INIT1.
- DONE lasts one cycle (done=1, busy=1), then IDLE.
- start while busy is ignored; there is no queueing.
- ram_wren is high only in INIT0, INIT1 and CALC.
- flush in IDLE clears memo_valid on the next edge.
- flush while busy sets flush_pend, which is applied on entry to IDLE. An in-flight result is still delivered.
- start and flush together in IDLE: the flush applies first, and the start takes the cold path.
- Arithmetic is DATA_W unsigned. Without the optional feature, sums wrap modulo 2^DATA_W.

Optional Feature:
- Macro: FIB_SAT_EN.
- Defined:
  - The adder saturates at all-ones.
  - Output ovf (1 bit) is a sticky flag set on the first saturating add; it is cleared by reset or flush.
  - Saturated values are written to the memo as-is.
- Undefined: wrap-around arithmetic and no ovf port.

Decomposition:
- fib_pkg holds:
  - the state enum (IDLE..DONE);
  - the base-case constant FIB_BASE=1;
  - the default widths.
- Sub-module fib_add: DATA_W adder with the FIB_SAT_EN saturate/ovf logic, instantiated once for the CALC sum.

Test Plan:
- After reset, start N=0 -> done in cycle 1, result=1; ram_wren never high.
- Cold start N=10 -> done in cycle 12, result=89 (0x0059); writes to addresses 0..10 in order, RAM[10]=89.
- Then start N=5 -> LOOKUP, done in cycle 3, result=8; no writes. Then start N=15 -> warm path, done in cycle 6, result=987 (0x03DB).
- Cold N=24 -> result=9489 (0x2511) with wrap. With FIB_SAT_EN: result=0xFFFF, ovf=1 from the add that produces index 24.
- Assert rst_n=0 during CALC of N=20 -> all outputs 0 immediately. Then N=3 -> cold path, done in cycle 5, result=3.
- flush pulsed while busy on N=8 -> result 34 is still delivered. Then N=4 -> cold path (INIT0 seen), result=5. N=300 -> err=1 in cycle 1.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci sequencer (FSM states, base value, widths).
// Optional saturating arithmetic is selected elsewhere with the FIB_SAT_EN macro.
package fib_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DEPTH_DEF  = 256;

    // fib(0) = fib(1) = FIB_BASE
    localparam int unsigned FIB_BASE = 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT0,
        INIT1,
        CALC,
        LOOKUP,
        RDWAIT,
        DONE
    } fib_state_e;

endpackage

// File: rtl/fib_add.sv
// DATA_W adder for the CALC step. With FIB_SAT_EN defined it clamps at all-ones
// and reports the saturating add on sat; otherwise it wraps modulo 2^DATA_W.
module fib_add
    import fib_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef FIB_SAT_EN
    output logic              sat,
`endif
    output logic [DATA_W-1:0] sum
);

`ifdef FIB_SAT_EN
    logic [DATA_W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sat = raw[DATA_W];
    assign sum = raw[DATA_W] ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci sequencer: drives the dual-port scratch RAM as a memo table and computes fib(N).
// Macro FIB_SAT_EN enables the saturating adder and the sticky ovf output.
//
// Handshake: start/n_in are sampled only while busy=0; done is a one-cycle pulse
// during which result/err are already valid, and they hold until the next done.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_in,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_q_b,
`ifdef FIB_SAT_EN
    output logic              ovf,
`endif
    output fib_state_e        dbg_state
);

    fib_state_e        state;
    fib_state_e        state_nx;

    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W-1:0] i_reg;
    logic [ADDR_W-1:0] i_nx;
    logic [ADDR_W-1:0] hi_idx;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] result_r;
    logic              err_r;
    logic              memo_valid;
    logic              flush_pend;

    logic              n_big;
    logic              n_small;
    logic              memo_live;
    logic              n_hit;

`ifdef FIB_SAT_EN
    logic              sat;
    logic              ovf_r;
`endif

    fib_add #(
        .DATA_W (DATA_W)
    ) u_add (
        .a   (prev),
        .b   (cur),
`ifdef FIB_SAT_EN
        .sat (sat),
`endif
        .sum (sum)
    );

    assign i_nx      = i_reg + ADDR_W'(1);
    assign n_big     = 32'(n_in) >= DEPTH;
    assign n_small   = n_in <= ADDR_W'(1);
    // A flush arriving with start wins, so the start sees an empty memo.
    assign memo_live = memo_valid && !flush;
    assign n_hit     = n_in <= hi_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_big || n_small) begin
                        state_nx = DONE;
                    end else if (memo_live && n_hit) begin
                        state_nx = LOOKUP;
                    end else if (memo_live) begin
                        state_nx = CALC;
                    end else begin
                        state_nx = INIT0;
                    end
                end
            end
            INIT0:   state_nx = INIT1;
            INIT1:   state_nx = CALC;
            CALC:    if (i_nx == n_reg) state_nx = DONE;
            LOOKUP:  state_nx = RDWAIT;
            RDWAIT:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_wren   = 1'b0;
        ram_addr_a = '0;
        ram_data_a = '0;
        ram_addr_b = '0;
        case (state)
            INIT0: begin
                ram_wren   = 1'b1;
                ram_data_a = DATA_W'(FIB_BASE);
            end
            INIT1: begin
                ram_wren   = 1'b1;
                ram_addr_a = ADDR_W'(1);
                ram_data_a = DATA_W'(FIB_BASE);
            end
            CALC: begin
                ram_wren   = 1'b1;
                ram_addr_a = i_nx;
                ram_data_a = sum;
            end
            LOOKUP: begin
                ram_addr_b = n_reg;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg      <= '0;
            i_reg      <= '0;
            hi_idx     <= '0;
            prev       <= '0;
            cur        <= '0;
            result_r   <= '0;
            err_r      <= 1'b0;
            memo_valid <= 1'b0;
            flush_pend <= 1'b0;
`ifdef FIB_SAT_EN
            ovf_r      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        memo_valid <= 1'b0;
`ifdef FIB_SAT_EN
                        ovf_r      <= 1'b0;
`endif
                    end
                    if (start) begin
                        n_reg <= n_in;
                        if (n_big) begin
                            result_r <= '0;
                            err_r    <= 1'b1;
                        end else if (n_small) begin
                            result_r <= DATA_W'(FIB_BASE);
                            err_r    <= 1'b0;
                        end else if (memo_live && !n_hit) begin
                            // Warm resume: prev/cur still hold fib(hi_idx-1), fib(hi_idx).
                            i_reg <= hi_idx;
                        end
                    end
                end
                INIT0: begin
                    if (flush) flush_pend <= 1'b1;
                end
                INIT1: begin
                    prev       <= DATA_W'(FIB_BASE);
                    cur        <= DATA_W'(FIB_BASE);
                    i_reg      <= ADDR_W'(1);
                    hi_idx     <= ADDR_W'(1);
                    memo_valid <= 1'b1;
                    if (flush) flush_pend <= 1'b1;
                end
                CALC: begin
                    prev   <= cur;
                    cur    <= sum;
                    i_reg  <= i_nx;
                    hi_idx <= i_nx;
                    if (i_nx == n_reg) begin
                        result_r <= sum;
                        err_r    <= 1'b0;
                    end
`ifdef FIB_SAT_EN
                    if (sat) ovf_r <= 1'b1;
`endif
                    if (flush) flush_pend <= 1'b1;
                end
                LOOKUP: begin
                    if (flush) flush_pend <= 1'b1;
                end
                RDWAIT: begin
                    result_r <= ram_q_b;
                    err_r    <= 1'b0;
                    if (flush) flush_pend <= 1'b1;
                end
                DONE: begin
                    // Deferred flush lands as we return to IDLE.
                    if (flush || flush_pend) begin
                        memo_valid <= 1'b0;
                        flush_pend <= 1'b0;
`ifdef FIB_SAT_EN
                        ovf_r      <= 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign result    = result_r;
    assign err       = err_r;
    assign dbg_state = state;
`ifdef FIB_SAT_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer: a vector table of whole transactions plus
// hand-written sequences for reset-during-CALC and result hold.
module tb_fib_sequencer;
    import fib_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 256;

`ifdef FIB_SAT_EN
    localparam logic [DATA_W-1:0] RES24 = 16'hFFFF;
`else
    localparam logic [DATA_W-1:0] RES24 = 16'h2511;
`endif

    typedef struct {
        int              n;
        bit              flush_start;
        bit              flush_mid;
        int              lat;
        logic [DATA_W-1:0] res;
        bit              err;
        int              nwr;
        int              wr_first;
        bit              init0;
        bit              ovf;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] n_in;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              err;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_q_b;
`ifdef FIB_SAT_EN
    logic              ovf;
`endif
    fib_state_e        dbg_state;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_q [$];

    int checks;
    int errors;

    fib_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_in       (n_in),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err),
        .ram_wren   (ram_wren),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_addr_b (ram_addr_b),
        .ram_q_b    (ram_q_b),
`ifdef FIB_SAT_EN
        .ovf        (ovf),
`endif
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous dual-port RAM model with a write log
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr_a] <= ram_data_a;
            wr_q.push_back(ram_addr_a);
        end
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // one transaction: cycle 0 is the cycle in which start is high
    task automatic run(input vec_t v, input int idx);
        int  got_lat;
        bit  seen_init0;
        bit  order_ok;
        string tag;
        tag = $sformatf("v%0d_n%0d", idx, v.n);
        @(posedge clk); #1;
        wr_q.delete();
        start = 1'b1;
        n_in  = ADDR_W'(v.n);
        flush = v.flush_start;
        seen_init0 = 1'b0;
        got_lat = -1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == 1 && v.flush_mid) flush = 1'b1;
            if (cyc == 2 && v.lat > 2) begin
                start = 1'b1;
                n_in  = ADDR_W'(7);
            end
            @(negedge clk);
            if (dbg_state == INIT0) seen_init0 = 1'b1;
            if (done) begin
                got_lat = cyc;
                break;
            end
            @(posedge clk); #1;
            flush = 1'b0;
            start = 1'b0;
        end
        chk({tag, "_latency"}, got_lat, v.lat);
        chk({tag, "_result"}, 32'(result), 32'(v.res));
        chk({tag, "_err"}, 32'(err), 32'(v.err));
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
`ifdef FIB_SAT_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        chk({tag, "_init0_seen"}, 32'(seen_init0), 32'(v.init0));
        chk({tag, "_write_count"}, wr_q.size(), v.nwr);
        order_ok = 1'b1;
        foreach (wr_q[k]) if (int'(wr_q[k]) != v.wr_first + k) order_ok = 1'b0;
        chk({tag, "_write_order"}, 32'(order_ok), 1);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 0);
    endtask

    vec_t vecs [8];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        n_in   = '0;
        for (int k = 0; k < 2**ADDR_W; k++) mem[k] = '0;

        //          n   fs fm lat  res     err nwr first init0 ovf
        vecs[0] = '{  0, 0, 0,  1, 16'd1,   0,  0,  0,   0,    0};
        vecs[1] = '{ 10, 0, 0, 12, 16'd89,  0, 11,  0,   1,    0};
        vecs[2] = '{  5, 0, 0,  3, 16'd8,   0,  0,  0,   0,    0};
        vecs[3] = '{ 15, 0, 0,  6, 16'd987, 0,  5, 11,   0,    0};
        vecs[4] = '{ 24, 1, 0, 26, RES24,   0, 25,  0,   1,    1};
        vecs[5] = '{  8, 0, 1,  3, 16'd34,  0,  0,  0,   0,    1};
        vecs[6] = '{  4, 0, 0,  6, 16'd5,   0,  5,  0,   1,    0};
        vecs[7] = '{300, 0, 0,  1, 16'd0,   1,  0,  0,   0,    0};

        #2;
        chk("reset_outputs", {27'd0, busy, done, err, ram_wren, 1'b0}, 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_addrs", {8'd0, ram_addr_a, ram_addr_b}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run(vecs[v], v);
            if (v == 1) chk("mem10_after_cold10", 32'(mem[10]), 89);
        end

        // reset asserted in the middle of CALC for N=20
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = ADDR_W'(20);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_calc_state", 32'(dbg_state), 32'(CALC));
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {27'd0, busy, done, err, ram_wren, 1'b0}, 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_addrs", {8'd0, ram_addr_a, ram_addr_b}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // memo must be cold after the abort
        run('{3, 0, 0, 5, 16'd3, 0, 4, 0, 1, 0}, 8);

        // result and err hold while idle
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("result_hold", 32'(result), 3);
        chk("err_hold", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
